fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the write port of the 16x8 FIFO among NREQ producers. Each producer presents a request plus one byte. The arbiter grants one owner at a time and caps each owner at BURST consecutive accepted writes when others are waiting. The winning byte is driven onto the FIFO's we/data_in, honouring the FIFO's full flag. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ byte producers.
// Latency: request to grant 1 cycle; writes are same-cycle combinational from the registered grant.
// Backpressure: fifo_full suppresses all accepts and freezes the burst count without moving the grant.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic                     fifo_full,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          accept,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     fifo_we,
    output logic [DW-1:0]            fifo_data_in
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] cnt_n;
    logic          others;
    logic          own_req;
    logic [OW:0]   pick_all;
    logic [OW:0]   pick_ex;

    // Returns {found, index}; the search begins just after 'after' and wraps,
    // so 'after' itself is visited last (or never when excl is set).
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   after,
                                            input logic            excl);
        logic          found;
        logic [OW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = after;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(after) + k) % NREQ;
            if (!found && r[j] && !(excl && k == NREQ)) begin
                found = 1'b1;
                idx   = OW'(j);
            end
        end
        return {found, idx};
    endfunction

    assign accept  = gnt & req & {NREQ{~fifo_full & ~rst}};
    assign fifo_we = |accept;

    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) fifo_data_in = fifo_data_in | req_data[DW*i +: DW];
        end
    end

    always_comb begin
        others = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && OW'(i) != owner) others = 1'b1;
        end
    end

    assign own_req  = req[owner];
    assign cnt_n    = burst_cnt + CW'(fifo_we);
    assign pick_all = rr_pick(req, owner, 1'b0);
    assign pick_ex  = rr_pick(req, owner, 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= OW'(NREQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_all[OW]) begin
                        gnt       <= NREQ'(1) << pick_all[OW-1:0];
                        owner     <= pick_all[OW-1:0];
                        burst_cnt <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (!own_req) begin
                        burst_cnt <= '0;
                        if (others) begin
                            gnt   <= NREQ'(1) << pick_ex[OW-1:0];
                            owner <= pick_ex[OW-1:0];
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (cnt_n == CW'(BURST)) begin
                        // Burst exhausted: hand off if anyone else waits, else restart the count.
                        burst_cnt <= '0;
                        if (others) begin
                            gnt   <= NREQ'(1) << pick_ex[OW-1:0];
                            owner <= pick_ex[OW-1:0];
                        end
                    end else begin
                        burst_cnt <= cnt_n;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  gnt;
    logic [3:0]  accept;
    logic [1:0]  owner;
    logic        fifo_we;
    logic [7:0]  fifo_data_in;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .gnt          (gnt),
        .accept       (accept),
        .owner        (owner),
        .fifo_we      (fifo_we),
        .fifo_data_in (fifo_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       we;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic f,
                       input logic [3:0] g, input logic [1:0] o,
                       input logic w, input logic [7:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.gnt = g; v.owner = o; v.we = w; v.data = d;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t       v;
        logic [3:0] exp_acc;
        logic [7:0] next_byte;

        // Each producer's byte is fixed here: p0=A0, p1=B1, p2=C2, p3=D3.
        rst       = 1'b1;
        req       = 4'b1111;
        fifo_full = 1'b0;
        req_data  = 32'hD3C2_B1A0;

        add(1, 4'hF, 0, 4'h0, 2'd3, 0, 8'h00);
        add(0, 4'hF, 0, 4'h0, 2'd3, 0, 8'h00);
        repeat (4) add(0, 4'hF, 0, 4'h1, 2'd0, 1, 8'hA0);
        repeat (4) add(0, 4'hF, 0, 4'h2, 2'd1, 1, 8'hB1);
        repeat (2) add(0, 4'hF, 0, 4'h4, 2'd2, 1, 8'hC2);
        repeat (5) add(0, 4'hF, 1, 4'h4, 2'd2, 0, 8'hC2);
        repeat (2) add(0, 4'hF, 0, 4'h4, 2'd2, 1, 8'hC2);
        repeat (4) add(0, 4'hF, 0, 4'h8, 2'd3, 1, 8'hD3);
        repeat (4) add(0, 4'hF, 0, 4'h1, 2'd0, 1, 8'hA0);
        add(0, 4'hF, 0, 4'h2, 2'd1, 1, 8'hB1);
        add(0, 4'h9, 0, 4'h2, 2'd1, 0, 8'hB1);  // owner 1 drops: next is 3, not 0
        add(0, 4'h9, 0, 4'h8, 2'd3, 1, 8'hD3);
        add(0, 4'h1, 0, 4'h8, 2'd3, 0, 8'hD3);
        add(0, 4'h1, 0, 4'h1, 2'd0, 1, 8'hA0);
        add(0, 4'h0, 0, 4'h1, 2'd0, 0, 8'hA0);
        add(0, 4'h9, 0, 4'h0, 2'd0, 0, 8'h00);  // idle, owner 0 kept: search starts at 1
        add(0, 4'h9, 0, 4'h8, 2'd3, 1, 8'hD3);
        add(0, 4'h2, 0, 4'h8, 2'd3, 0, 8'hD3);
        add(0, 4'h2, 0, 4'h2, 2'd1, 1, 8'hB1);
        add(1, 4'h3, 0, 4'h2, 2'd1, 0, 8'hB1);  // reset mid-burst kills the write
        add(0, 4'h3, 0, 4'h0, 2'd3, 0, 8'h00);
        add(0, 4'h3, 0, 4'h1, 2'd0, 1, 8'hA0);

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            rst       = v.rst;
            req       = v.req;
            fifo_full = v.full;
            #1;
            exp_acc = v.gnt & v.req & {4{~v.full & ~v.rst}};
            check("gnt",    i, 32'(gnt),          32'(v.gnt));
            check("owner",  i, 32'(owner),        32'(v.owner));
            check("we",     i, 32'(fifo_we),      32'(v.we));
            check("data",   i, 32'(fifo_data_in), 32'(v.data));
            check("accept", i, 32'(accept),       32'(exp_acc));
        end

        // Single requester streams 0x10..0x1F back to back across burst boundaries.
        @(negedge clk);
        rst = 1'b1; req = 4'b0100; fifo_full = 1'b0;
        next_byte = 8'h10;
        req_data  = {8'h00, next_byte, 16'h0000};
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stream_idle_gnt", 0, 32'(gnt), 32'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            #1;
            check("stream_gnt",  k, 32'(gnt),          32'h4);
            check("stream_we",   k, 32'(fifo_we),      32'h1);
            check("stream_data", k, 32'(fifo_data_in), 32'(8'h10 + 8'(k)));
            @(posedge clk);
            if (accept[2]) next_byte = next_byte + 8'h01;
            #1;
            req_data = {8'h00, next_byte, 16'h0000};
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        check("stream_end_byte", 16, 32'(next_byte), 32'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
